// File: rtl/pll_reset_sequencer_pkg.sv
// rst_seq_pkg
// Shared types for the PLL reset sequencer: the FSM state enum, its fixed
// encodings, and the helper that sizes the shared cycle counter.
// No ports.

package rst_seq_pkg;

  localparam logic [1:0] ENC_WAIT_LOCK = 2'b00;
  localparam logic [1:0] ENC_STABILIZE = 2'b01;
  localparam logic [1:0] ENC_RUN       = 2'b10;
  localparam logic [1:0] ENC_SW_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    WAIT_LOCK = ENC_WAIT_LOCK,
    STABILIZE = ENC_STABILIZE,
    RUN       = ENC_RUN,
    SW_HOLD   = ENC_SW_HOLD
  } rst_seq_state_t;

  // One counter serves both the stabilization window and the software hold,
  // so it is sized for the longer of the two and can never wrap.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
// Groups the sequencer's functional signals into one bundle.
//   pll_locked    : PLL lock flag, asynchronous to clk
//   sw_rst_req    : single-cycle software reset request from the core
//   core_rst      : active-high registered reset to the core
//   state_dbg     : current sequencer state
//   lock_loss_cnt : saturating count of lock losses seen while running
// Modports: master drives the requests and observes the results,
//           slave is the sequencer itself.

interface pll_reset_sequencer_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  pll_locked;
  logic                  sw_rst_req;
  logic                  core_rst;
  logic [1:0]            state_dbg;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    output pll_locked,
    output sw_rst_req,
    input  core_rst,
    input  state_dbg,
    input  lock_loss_cnt
  );

  modport slave (
    input  pll_locked,
    input  sw_rst_req,
    output core_rst,
    output state_dbg,
    output lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer_bit_sync.sv
// bit_sync
// Multi-flop synchronizer for a single asynchronous input, cleared to 0 by
// an asynchronous active-high reset. Used for the PLL lock flag and reusable
// for other asynchronous inputs such as buttons.
//   clk : destination clock
//   rst : asynchronous active-high clear
//   d   : asynchronous input
//   q   : d delayed through STAGES flops (STAGES >= 2)

module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Produces the core reset from the 25 MHz PLL output clock and its lock
// flag. The core is held in reset until the synchronized lock has been
// stable for STABLE_CYCLES cycles; reset is re-asserted on lock loss and
// held for SW_RST_CYCLES cycles on a software request.
//   clk  : 25 MHz PLL output clock
//   rst  : asynchronous active-high reset (board button)
//   bus  : pll_reset_sequencer_if.slave (pll_locked, sw_rst_req in;
//          core_rst, state_dbg, lock_loss_cnt out)
// Optional build macro PLL_RST_LOSS_COUNT_EN: when defined, lock_loss_cnt
// counts RUN/SW_HOLD -> WAIT_LOCK transitions, saturating and cleared only
// by rst; when undefined it is tied to zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | no synchronized lock; core held in reset
// STABILIZE | lock seen, counting STABLE_CYCLES consecutive locked cycles
// RUN       | core out of reset; watching for lock loss / sw request
// SW_HOLD   | software reset, core held for SW_RST_CYCLES cycles

module pll_reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int SW_RST_CYCLES = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_reset_sequencer_if.slave  bus
);
  localparam int CNT_W = cnt_width(STABLE_CYCLES, SW_RST_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_RST_CYCLES - 1);

  logic             locked_s;
  rst_seq_state_t   state;
  rst_seq_state_t   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             core_rst_q;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  // Lock loss is tested first in every state so it always wins over a
  // simultaneous software request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABILIZE;
          cnt_nxt   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (bus.sw_rst_req) begin
          state_nxt = SW_HOLD;
          cnt_nxt   = '0;
        end
      end
      SW_HOLD: begin
        // Further requests here are deliberately ignored so the hold
        // length is not extended.
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == SW_LAST) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
      end
    endcase
  end

  // core_rst is decoded from the next state so it changes on the same edge
  // as the state and never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      core_rst_q <= (state_nxt != RUN);
    end
  end

  assign bus.core_rst  = core_rst_q;
  assign bus.state_dbg = state;

`ifdef PLL_RST_LOSS_COUNT_EN
  logic                  loss_evt;
  logic [LOSS_CNT_W-1:0] loss_cnt;

  assign loss_evt = ((state == RUN) || (state == SW_HOLD)) && !locked_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (loss_evt && (loss_cnt != {LOSS_CNT_W{1'b1}})) begin
      loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    end
  end

  assign bus.lock_loss_cnt = loss_cnt;
`else
  assign bus.lock_loss_cnt = {LOSS_CNT_W{1'b0}};
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Generates the system reset for the multicycle RISC-V core from the 25 MHz PLL output clock and the PLL lock indication. Sits directly downstream of the 25 MHz PLL clock generator.
- Consumes outclk_0 as clk and the asynchronous locked as pll_locked.
- Holds the core in reset until lock has been stable for a programmable time.
- Re-asserts reset on lock loss, and also on a software reset request.

Parameters:
- SYNC_STAGES, 2: flop stages synchronizing pll_locked; legal values >=2.
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before releasing reset; legal values >=1.
- SW_RST_CYCLES, 16: core_rst hold length after a software reset request; legal values >=1.
- LOSS_CNT_W, 8: width of the lock-loss event counter.

Ports:
- clk  in  1  25 MHz clock, the PLL output clock.
- rst  in  1  asynchronous active-high reset, e.g. from the board button.
- pll_locked  in  1  PLL lock flag; asynchronous to clk.
- sw_rst_req  in  1  synchronous single-cycle software reset request from the core.
- core_rst  out  1  active-high reset to the core; registered.
- state_dbg  out  2  current FSM state.
- lock_loss_cnt  out  LOSS_CNT_W  saturating count of lock losses seen in RUN.

Behaviour:
Reset (rst=1, asynchronous):
- core_rst=1 immediately.
- state=WAIT_LOCK, cycle counter=0, all sync flops=0, lock_loss_cnt=0.
- Reset release takes effect on the next clk edge.

Lock synchronization:
- locked_s is pll_locked delayed through SYNC_STAGES flops.
- The FSM uses only locked_s.

State encoding: WAIT_LOCK=00, STABILIZE=01, RUN=10, SW_HOLD=11.

State transitions (cnt is the cycle counter):
- WAIT_LOCK: if locked_s=1, go to STABILIZE with cnt=0.
- STABILIZE: if locked_s=0, go to WAIT_LOCK. Otherwise, if cnt==STABLE_CYCLES-1, go to RUN; else cnt++.
- RUN: if locked_s=0, go to WAIT_LOCK and count a loss event. Otherwise, if sw_rst_req=1, go to SW_HOLD with cnt=0.
- SW_HOLD: if locked_s=0, go to WAIT_LOCK and count a loss event. Otherwise, if cnt==SW_RST_CYCLES-1, go to RUN; else cnt++.

Output rules:
- core_rst is registered from next_state; core_rst=0 exactly when state==RUN.
- state_dbg = state.

Latency:
- Release: core_rst falls on the (SYNC_STAGES+STABLE_CYCLES+1)th rising edge, counting the first edge that samples pll_locked=1.
- Lock loss: core_rst rises on the (SYNC_STAGES+1)th edge after pll_locked falls.
- Software reset: core_rst rises on the edge that samples sw_rst_req=1 in RUN, and stays high for SW_RST_CYCLES cycles.

Priorities and boundary conditions:
- Lock loss beats sw_rst_req when both occur in the same cycle.
- sw_rst_req is ignored outside RUN. A repeat request in SW_HOLD does not restart the count.
- A lock glitch shorter than one synchronized cycle in STABILIZE still restarts the full stabilization window.
- The counter width is $clog2(max(STABLE_CYCLES,SW_RST_CYCLES)+1); it never wraps.
- rst asserted mid-sequence aborts immediately to the reset values above.

Optional Feature:
Macro: PLL_RST_LOSS_COUNT_EN
- Defined: lock_loss_cnt increments by 1 on every RUN->WAIT_LOCK or SW_HOLD->WAIT_LOCK transition. It saturates at 2^LOSS_CNT_W-1 and is cleared only by rst.
- Undefined: the counter logic is absent and lock_loss_cnt is tied to 0. The port remains present.

Decomposition:
- Package rst_seq_pkg: state enum typedef rst_seq_state_t and the four encoding constants.
- Sub-module bit_sync: parameterized SYNC_STAGES flop chain with asynchronous clear. It is reused for other async inputs such as the buttons.

Test Plan:
Bench parameters: SYNC_STAGES=2, STABLE_CYCLES=8, SW_RST_CYCLES=4 unless noted.
- Power-up: rst=1 for 3 cycles with pll_locked=0 -> core_rst=1, state_dbg=00, lock_loss_cnt=0; no change after rst falls while pll_locked=0.
- Lock acquisition: pll_locked rises, sampled on edge E -> state_dbg=01 after edge E+2; core_rst falls on edge E+10; state_dbg=10.
- Lock glitch: pll_locked low for 3 cycles while in STABILIZE -> return to 00. After relock, core_rst falls a full 11 edges after the relock sample edge.
- Software reset: one-cycle sw_rst_req in RUN -> core_rst=1 for exactly 4 cycles, state_dbg=11, then back to 10. A second request inside SW_HOLD leaves the duration unchanged.
- Lock loss in RUN, with macro defined: pll_locked falls -> core_rst=1 on the 3rd edge and lock_loss_cnt 0->1. Repeat 300 times with LOSS_CNT_W=8 -> counter saturates at 255.
- Async reset mid-STABILIZE, plus simultaneous lock loss and sw_rst_req in RUN:
  - rst pulse mid-STABILIZE -> core_rst=1 with no clock edge, state 00.
  - Simultaneous case -> next state is 00, not 11.
